// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the mtm_Alu response serializer and its bench.
package mtm_alu_pkg;

  localparam int         FRAME_BITS = 11;
  localparam logic [2:0] CRC3_POLY  = 3'b011;

  typedef enum logic {
    DATA_FRAME = 1'b0,
    CMD_FRAME  = 1'b1
  } frame_type_t;

  typedef enum logic [2:0] {
    AND_OP = 3'b000,
    OR_OP  = 3'b001,
    ADD_OP = 3'b100,
    SUB_OP = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  // Line order, MSB first: start, type, payload, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input frame_type_t ftype,
                                                       input logic [7:0]  payload);
    return {1'b0, ftype, payload, 1'b1};
  endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC-3 (x^3+x+1, init 0) over an MSB-first message augmented by three zeros.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
#(
  parameter int MSG_W = 37
) (
  input  logic [MSG_W-1:0] msg,
  output logic [2:0]       crc
);

  logic [MSG_W+2:0] aug;
  logic [2:0]       rem;
  logic             fb;

  always_comb begin
    aug = {msg, 3'b000};
    rem = '0;
    fb  = 1'b0;
    for (int i = MSG_W + 2; i >= 0; i--) begin
      fb  = rem[2];
      rem = {rem[1:0], aug[i]};
      if (fb) rem = rem ^ CRC3_POLY;
    end
    crc = rem;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Serializes one ALU result (data frames + CMD frame) or one error CMD frame onto sout.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_FRAMES  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_err,
  input  logic [8*DATA_FRAMES-1:0] in_c,
  input  logic [3:0]               in_flags,
  input  logic [2:0]               in_err_flags,
  output logic                     sout,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int C_W   = 8 * DATA_FRAMES;
  localparam int FC_W  = $clog2(DATA_FRAMES + 1);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [FC_W-1:0]  LAST_DATA = FC_W'(DATA_FRAMES);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

  tx_state_t             state;
  logic [FRAME_BITS-1:0] sreg;
  logic [3:0]            bit_cnt;
  logic [FC_W-1:0]       frame_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tail;

  logic                  err_q;
  logic [C_W-1:0]        c_q;
  logic [3:0]            flags_q;
  logic [2:0]            err_flags_q;
  logic [2:0]            crc_q;
  logic [2:0]            crc_w;

  logic accept, emit, frame_end, last_frame;

  mtm_alu_crc3 #(.MSG_W(C_W + 5)) u_crc (
    .msg ({in_c, 1'b0, in_flags}),
    .crc (crc_w)
  );

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [FC_W-1:0] idx,
                                                        input logic            err,
                                                        input logic [C_W-1:0]  c,
                                                        input logic [3:0]      flags,
                                                        input logic [2:0]      errf,
                                                        input logic [2:0]      crc);
    if (err)
      return make_frame(CMD_FRAME, {1'b1, errf, errf, ^{1'b1, errf, errf}});
    else if (idx < LAST_DATA)
      return make_frame(DATA_FRAME, c[C_W-1-8*int'(idx) -: 8]);
    else
      return make_frame(CMD_FRAME, {1'b0, flags, crc});
  endfunction

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign emit       = (state == SHIFT) && (div_cnt == '0) && !tail;
  assign frame_end  = emit && (bit_cnt == BIT_LAST);
  assign last_frame = err_q || (frame_cnt == LAST_DATA);

  // Request capture and frame shift register: data only, no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      err_q       <= in_err;
      c_q         <= in_c;
      flags_q     <= in_flags;
      err_flags_q <= in_err_flags;
      crc_q       <= crc_w;
      sreg        <= build_frame('0, in_err, in_c, in_flags, in_err_flags, crc_w);
    end else if (emit) begin
      if (frame_end && !last_frame)
        sreg <= build_frame(frame_cnt + 1'b1, err_q, c_q, flags_q, err_flags_q, crc_q);
      else
        sreg <= {sreg[FRAME_BITS-2:0], 1'b1};
    end
  end

  // Control FSM; tail marks that the final stop bit is on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      sout      <= 1'b1;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      div_cnt   <= '0;
      tail      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            state     <= SHIFT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            div_cnt   <= '0;
            tail      <= 1'b0;
          end
        end
        SHIFT: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          if (div_cnt == '0 && tail) begin
            state   <= DONE;
            sout    <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            div_cnt <= '0;
          end else if (emit) begin
            sout <= sreg[FRAME_BITS-1];
            if (frame_end) begin
              bit_cnt <= '0;
              if (last_frame) tail <= 1'b1;
              else            frame_cnt <= frame_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
